// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA controller blocks.
package dma_pkg;

    // One-hot arbiter states
    typedef enum logic [3:0] {
        StIdle    = 4'b0001,
        StReq     = 4'b0010,
        StGrant   = 4'b0100,
        StRelease = 4'b1000
    } arb_state_t;

    typedef logic [1:0] channel_t;

    // Slot [1:0] is highest priority, slot [7:6] lowest.
    localparam logic [7:0] DEFAULT_PRIORITY_ORDER = 8'b11_10_01_00;

    // Serviced channel k drops to the lowest slot; k+1 becomes the highest.
    function automatic logic [7:0] rotate_order(input channel_t k);
        return {k, channel_t'(k + 2'd3), channel_t'(k + 2'd2), channel_t'(k + 2'd1)};
    endfunction

endpackage

// File: rtl/dma_priority_arbiter_if.sv
// Request/handshake bundle between DREQ pins, CPU hold logic, tC and the arbiter.
// Optional port hldaTimeout exists only when DMA_ARB_HLDA_TIMEOUT_EN is defined.
interface dma_priority_arbiter_if;
    logic [3:0] DREQ;
    logic [3:0] maskReg;
    logic       priorityType;
    logic       dreqSense;
    logic       dackSense;
    logic       controllerDisable;
    logic       HLDA;
    logic       transferDone;
    logic       HRQ;
    logic [3:0] DACK;
    logic [1:0] grantChannel;
    logic       grantValid;
    logic [7:0] priorityOrder;
`ifdef DMA_ARB_HLDA_TIMEOUT_EN
    logic       hldaTimeout;
`endif

    // Environment side: pins, CPU and tC
    modport master (
        output DREQ, maskReg, priorityType, dreqSense, dackSense, controllerDisable,
        output HLDA, transferDone,
`ifdef DMA_ARB_HLDA_TIMEOUT_EN
        input  hldaTimeout,
`endif
        input  HRQ, DACK, grantChannel, grantValid, priorityOrder
    );

    // Arbiter side
    modport slave (
        input  DREQ, maskReg, priorityType, dreqSense, dackSense, controllerDisable,
        input  HLDA, transferDone,
`ifdef DMA_ARB_HLDA_TIMEOUT_EN
        output hldaTimeout,
`endif
        output HRQ, DACK, grantChannel, grantValid, priorityOrder
    );
endinterface

// File: rtl/dma_priority_resolver.sv
// Combinational priority resolver: picks the first requesting channel in priorityOrder.
module dma_priority_resolver
    import dma_pkg::*;
(
    input  logic [3:0] req,
    input  logic [7:0] priorityOrder,
    output channel_t   winner,
    output logic       anyReq
);

    // Scan from lowest slot up so the highest-priority match is written last
    always_comb begin
        winner = priorityOrder[1:0];
        for (int i = 3; i >= 0; i--) begin
            if (req[priorityOrder[2*i +: 2]]) begin
                winner = priorityOrder[2*i +: 2];
            end
        end
    end

    assign anyReq = |req;

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel priority arbiter and HRQ/HLDA bus-request sequencer.
// Optional macro DMA_ARB_HLDA_TIMEOUT_EN adds an HLDA wait timeout in REQ.
module dma_priority_arbiter
    import dma_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned CH_W         = 2,
    parameter int unsigned HLDA_TIMEOUT = 255
) (
    input logic                   CLK,
    input logic                   RESET,
    dma_priority_arbiter_if.slave bus
);

    localparam logic [NUM_CH-1:0] OneCh = NUM_CH'(1);

    arb_state_t        state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [7:0]        order_q, order_d;
    logic              hrq_q, hrq_d;
    logic              valid_q, valid_d;
    logic [NUM_CH-1:0] dack_q, dack_d;
    logic [NUM_CH-1:0] dack_act;
    logic [NUM_CH-1:0] req;
    channel_t          winner;
    logic              any_req;

`ifdef DMA_ARB_HLDA_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(HLDA_TIMEOUT - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;
`endif

    assign req = (bus.DREQ ^ {NUM_CH{bus.dreqSense}}) & ~bus.maskReg;

    dma_priority_resolver u_resolver (
        .req          (req),
        .priorityOrder(order_q),
        .winner       (winner),
        .anyReq       (any_req)
    );

    // Next-state, channel latch, priority update and registered-output values
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        order_d = order_q;
`ifdef DMA_ARB_HLDA_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (!bus.priorityType) order_d = DEFAULT_PRIORITY_ORDER;
                if (!bus.controllerDisable && any_req) begin
                    grant_d = winner;
                    state_d = StReq;
                end
            end
            StReq: begin
                // Losing the request wins over a simultaneous HLDA
                if (!req[grant_q]) begin
                    state_d = StRelease;
                end else if (bus.HLDA) begin
                    state_d = StGrant;
`ifdef DMA_ARB_HLDA_TIMEOUT_EN
                end else if (cnt_q == TimeoutLast) begin
                    state_d   = StRelease;
                    timeout_d = 1'b1;
`endif
                end
            end
            StGrant: begin
                if (bus.transferDone) begin
                    state_d = StRelease;
                    if (bus.priorityType) order_d = rotate_order(grant_q);
                end
            end
            StRelease: begin
                if (!bus.HLDA) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        hrq_d    = (state_d == StReq) || (state_d == StGrant);
        valid_d  = (state_d == StGrant);
        dack_act = valid_d ? (OneCh << grant_d) : '0;
        dack_d   = dack_act ^ {NUM_CH{bus.dackSense}};
`ifdef DMA_ARB_HLDA_TIMEOUT_EN
        cnt_d = ((state_q == StReq) && (state_d == StReq)) ? cnt_q + 8'd1 : 8'd0;
`endif
    end

    // State and output registers; reset forces DACK to 0 regardless of polarity
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            grant_q <= '0;
            order_q <= DEFAULT_PRIORITY_ORDER;
            hrq_q   <= 1'b0;
            valid_q <= 1'b0;
            dack_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            order_q <= order_d;
            hrq_q   <= hrq_d;
            valid_q <= valid_d;
            dack_q  <= dack_d;
        end
    end

`ifdef DMA_ARB_HLDA_TIMEOUT_EN
    // HLDA wait counter and one-cycle timeout pulse
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.hldaTimeout = timeout_q;
`endif

    assign bus.HRQ           = hrq_q;
    assign bus.grantValid    = valid_q;
    assign bus.DACK          = dack_q;
    assign bus.grantChannel  = grant_q;
    assign bus.priorityOrder = order_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed self-checking bench for dma_priority_arbiter.
module tb_dma_priority_arbiter;

    logic CLK;
    logic RESET;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    dma_priority_arbiter_if bus ();

    dma_priority_arbiter #(
        .NUM_CH      (4),
        .CH_W        (2),
        .HLDA_TIMEOUT(8)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One full grant: wait for HRQ, HLDA two cycles later, transferDone, release
    task automatic service(input string tag, input logic [1:0] ch, input logic [3:0] dack_on,
                           input logic [3:0] dack_off, input logic [7:0] order_after);
        for (int i = 0; i < 10 && bus.HRQ !== 1'b1; i++) tick();
        check({tag, "_hrq"}, 8'(bus.HRQ), 8'd1);
        check({tag, "_ch"}, 8'(bus.grantChannel), 8'(ch));
        check({tag, "_dack_req"}, 8'(bus.DACK), 8'(dack_off));
        tick();
        check({tag, "_hrq_hold"}, 8'(bus.HRQ), 8'd1);
        check({tag, "_gv_req"}, 8'(bus.grantValid), 8'd0);
        bus.HLDA = 1'b1;
        tick();
        check({tag, "_dack_grant"}, 8'(bus.DACK), 8'(dack_on));
        check({tag, "_gv_grant"}, 8'(bus.grantValid), 8'd1);
        bus.transferDone = 1'b1;
        tick();
        bus.transferDone = 1'b0;
        bus.HLDA         = 1'b0;
        check({tag, "_dack_rel"}, 8'(bus.DACK), 8'(dack_off));
        check({tag, "_hrq_rel"}, 8'(bus.HRQ), 8'd0);
        check({tag, "_order"}, bus.priorityOrder, order_after);
    endtask

    initial begin
        RESET                 = 1'b1;
        bus.DREQ              = 4'b0000;
        bus.maskReg           = 4'b0000;
        bus.priorityType      = 1'b0;
        bus.dreqSense         = 1'b0;
        bus.dackSense         = 1'b0;
        bus.controllerDisable = 1'b0;
        bus.HLDA              = 1'b0;
        bus.transferDone      = 1'b0;
        #1;
        check("rst_hrq", 8'(bus.HRQ), 8'd0);
        check("rst_dack", 8'(bus.DACK), 8'h0);
        check("rst_gv", 8'(bus.grantValid), 8'd0);
        check("rst_ch", 8'(bus.grantChannel), 8'd0);
        check("rst_order", bus.priorityOrder, 8'hE4);
        tick();
        RESET = 1'b0;
        tick();

        // Fixed priority: channel 1 wins over 2 and 3
        bus.DREQ = 4'b1110;
        service("fixed", 2'd1, 4'b0010, 4'b0000, 8'hE4);
        bus.DREQ = 4'b0000;
        tick();
        tick();

        // Rotating priority with all channels requesting
        bus.priorityType = 1'b1;
        bus.DREQ         = 4'b1111;
        service("rot0", 2'd0, 4'b0001, 4'b0000, 8'h39);
        service("rot1", 2'd1, 4'b0010, 4'b0000, 8'h4E);
        service("rot2", 2'd2, 4'b0100, 4'b0000, 8'h93);
        service("rot3", 2'd3, 4'b1000, 4'b0000, 8'hE4);
        bus.DREQ         = 4'b0000;
        bus.priorityType = 1'b0;
        tick();
        tick();

        // Request withdrawn in REQ together with HLDA rising
        bus.DREQ = 4'b0001;
        for (int i = 0; i < 10 && bus.HRQ !== 1'b1; i++) tick();
        check("wd_hrq", 8'(bus.HRQ), 8'd1);
        bus.DREQ = 4'b0000;
        bus.HLDA = 1'b1;
        tick();
        check("wd_hrq_low", 8'(bus.HRQ), 8'd0);
        check("wd_dack", 8'(bus.DACK), 8'h0);
        check("wd_gv", 8'(bus.grantValid), 8'd0);
        tick();
        check("wd_hold_rel", 8'(bus.HRQ), 8'd0);
        check("wd_dack2", 8'(bus.DACK), 8'h0);
        bus.HLDA = 1'b0;
        tick();

        // Mask plus inverted DREQ/DACK polarity
        bus.maskReg   = 4'b0001;
        bus.dreqSense = 1'b1;
        bus.dackSense = 1'b1;
        bus.DREQ      = 4'b1100;
        service("pol", 2'd1, 4'b1101, 4'b1111, 8'hE4);
        bus.DREQ = 4'b1111;
        tick();
        check("pol_idle_dack", 8'(bus.DACK), 8'hF);
        bus.maskReg   = 4'b0000;
        bus.dreqSense = 1'b0;
        bus.dackSense = 1'b0;
        bus.DREQ      = 4'b0000;
        tick();
        check("pol_restore_dack", 8'(bus.DACK), 8'h0);

        // controllerDisable blocks arbitration
        bus.controllerDisable = 1'b1;
        bus.DREQ              = 4'b0001;
        tick();
        check("cd_hrq0", 8'(bus.HRQ), 8'd0);
        tick();
        check("cd_hrq1", 8'(bus.HRQ), 8'd0);
        bus.controllerDisable = 1'b0;
        tick();
        check("cd_hrq_on", 8'(bus.HRQ), 8'd1);

        // Rotate once, regrant, then reset asynchronously mid-GRANT
        bus.priorityType = 1'b1;
        bus.HLDA         = 1'b1;
        tick();
        check("pre_dack", 8'(bus.DACK), 8'h1);
        bus.transferDone = 1'b1;
        tick();
        bus.transferDone = 1'b0;
        bus.HLDA         = 1'b0;
        check("pre_order", bus.priorityOrder, 8'h39);
        for (int i = 0; i < 10 && bus.HRQ !== 1'b1; i++) tick();
        check("pre2_hrq", 8'(bus.HRQ), 8'd1);
        bus.HLDA = 1'b1;
        tick();
        check("pre2_dack", 8'(bus.DACK), 8'h1);
        #2;
        RESET = 1'b1;
        #1;
        check("arst_hrq", 8'(bus.HRQ), 8'd0);
        check("arst_dack", 8'(bus.DACK), 8'h0);
        check("arst_order", bus.priorityOrder, 8'hE4);
        check("arst_gv", 8'(bus.grantValid), 8'd0);
        bus.DREQ = 4'b0000;
        bus.HLDA = 1'b0;
        #3;
        RESET = 1'b0;
        tick();

        // transferDone outside GRANT must not rotate
        bus.transferDone = 1'b1;
        tick();
        bus.transferDone = 1'b0;
        check("td_idle_order", bus.priorityOrder, 8'hE4);
        check("td_idle_hrq", 8'(bus.HRQ), 8'd0);

`ifdef DMA_ARB_HLDA_TIMEOUT_EN
        // HLDA never arrives: timeout after 8 REQ cycles, then re-arbitrate
        bus.DREQ = 4'b0001;
        for (int i = 0; i < 10 && bus.HRQ !== 1'b1; i++) tick();
        check("to_hrq", 8'(bus.HRQ), 8'd1);
        for (int i = 0; i < 7; i++) tick();
        check("to_not_yet", 8'(bus.hldaTimeout), 8'd0);
        check("to_hrq_held", 8'(bus.HRQ), 8'd1);
        tick();
        check("to_pulse", 8'(bus.hldaTimeout), 8'd1);
        check("to_hrq_drop", 8'(bus.HRQ), 8'd0);
        tick();
        check("to_pulse_end", 8'(bus.hldaTimeout), 8'd0);
        tick();
        check("to_rearb", 8'(bus.HRQ), 8'd1);
        bus.DREQ = 4'b0000;
        tick();
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
